boot_streamer: RTL and testbench

//  Host/test-side peer of the UART boot loader. On start, streams N_WORDS 16-bit words from a local

---
 rtl/boot_streamer_if.sv | 23 ++
 rtl/boot_streamer.sv | 176 +++++++++++++++++
 tb/tb_boot_streamer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/boot_streamer_if.sv
// ROM read port plus UART byte transmit/receive paths between the boot streamer and its environment.
// The streamer is the master; the ROM and UART side is the slave.
interface boot_streamer_if #(
  parameter int ADR_W = 6
);
  logic [ADR_W-1:0] rom_adr;
  logic [15:0]      rom_data;
  logic [7:0]       tx_dat;
  logic             tx_en;
  logic             tx_full;
  logic [7:0]       rx_dat;
  logic             rx_en;

  modport master (
    output rom_adr, tx_dat, tx_en,
    input  rom_data, tx_full, rx_dat, rx_en
  );

  modport slave (
    input  rom_adr, tx_dat, tx_en,
    output rom_data, tx_full, rx_dat, rx_en
  );
endinterface

// File: rtl/boot_streamer.sv
// Streams a ROM image as bytes (high byte first) to a UART transmitter, requests a scan, then
// checks the echoed bytes against the ROM and reports pass/fail, error count and first bad address.
module boot_streamer #(
  parameter int N_WORDS    = 64,
  parameter int ADR_W      = 6,
  parameter int RX_TIMEOUT = 200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  boot_streamer_if.master    bus,
  output logic               scan_req_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic [ADR_W:0]     err_count_o,
  output logic [ADR_W-1:0]   first_err_adr_o
);
  localparam int               TMR_W    = $clog2(RX_TIMEOUT + 1);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(N_WORDS - 1);
  localparam logic [ADR_W:0]   MAX_ERR  = (ADR_W + 1)'(N_WORDS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_SEND_HI, S_SEND_LO, S_NEXT, S_SCAN, S_RX_HI, S_RX_LO, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ADR_W-1:0] rom_adr_q, rom_adr_d;
  logic [15:0]      word_q, word_d;
  logic [7:0]       hi_q, hi_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ADR_W:0]   err_count_q, err_count_d;
  logic [ADR_W-1:0] first_err_adr_q, first_err_adr_d;
  logic             timeout_q, timeout_d;
  logic             scan_req_q, scan_req_d;
  logic             tx_en_last_q;
  logic             tx_en;
  logic [7:0]       tx_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rom_adr_q       <= '0;
      word_q          <= '0;
      hi_q            <= '0;
      timer_q         <= '0;
      err_count_q     <= '0;
      first_err_adr_q <= '0;
      timeout_q       <= 1'b0;
      scan_req_q      <= 1'b0;
      tx_en_last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q         <= state_d;
      rom_adr_q       <= rom_adr_d;
      word_q          <= word_d;
      hi_q            <= hi_d;
      timer_q         <= timer_d;
      err_count_q     <= err_count_d;
      first_err_adr_q <= first_err_adr_d;
      timeout_q       <= timeout_d;
      scan_req_q      <= scan_req_d;
      tx_en_last_q    <= tx_en;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d         = state_q;
    rom_adr_d       = rom_adr_q;
    word_d          = word_q;
    hi_d            = hi_q;
    timer_d         = timer_q;
    err_count_d     = err_count_q;
    first_err_adr_d = first_err_adr_q;
    timeout_d       = timeout_q;
    scan_req_d      = scan_req_q;
    tx_en           = 1'b0;
    tx_dat          = '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          err_count_d     = '0;
          first_err_adr_d = '0;
          timeout_d       = 1'b0;
          scan_req_d      = 1'b0;
          rom_adr_d       = '0;
          state_d         = S_RD;
        end
      end
      S_RD: begin
        word_d  = bus.rom_data;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        tx_dat = word_q[15:8];
        if (!bus.tx_full) begin
          tx_en   = 1'b1;
          state_d = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        // The previous-cycle strobe check keeps the high and low byte writes at least 2 cycles apart.
        tx_dat = word_q[7:0];
        if (!bus.tx_full && !tx_en_last_q) begin
          tx_en   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (rom_adr_q == LAST_ADR) begin
          rom_adr_d  = '0;
          timer_d    = '0;
          scan_req_d = 1'b1;
          state_d    = S_SCAN;
        end else begin
          rom_adr_d = rom_adr_q + 1'b1;
          state_d   = S_RD;
        end
      end
      S_SCAN, S_RX_HI: begin
        if (bus.rx_en) begin
          hi_d       = bus.rx_dat;
          timer_d    = '0;
          scan_req_d = 1'b0;
          state_d    = S_RX_LO;
        end else if (timer_q == TMR_LAST) begin
          timeout_d  = 1'b1;
          scan_req_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
          state_d = S_RX_HI;
        end
      end
      S_RX_LO: begin
        if (bus.rx_en) begin
          timer_d = '0;
          if ({hi_q, bus.rx_dat} != bus.rom_data) begin
            if (err_count_q != MAX_ERR) err_count_d = err_count_q + 1'b1;
            if (err_count_q == '0)      first_err_adr_d = rom_adr_q;
          end
          if (rom_adr_q == LAST_ADR) begin
            state_d = S_DONE;
          end else begin
            rom_adr_d = rom_adr_q + 1'b1;
            state_d   = S_RX_HI;
          end
        end else if (timer_q == TMR_LAST) begin
          timeout_d  = 1'b1;
          scan_req_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The ROM sees the next address, so its registered data is already valid while in RD / RX_LO.
  assign bus.rom_adr     = rom_adr_d;
  assign bus.tx_en       = tx_en;
  assign bus.tx_dat      = tx_dat;

  assign scan_req_o      = scan_req_q;
  assign busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign pass_o          = (state_q == S_DONE) && (err_count_q == '0) && !timeout_q;
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_count_q;
  assign first_err_adr_o = first_err_adr_q;
endmodule

// File: tb/tb_boot_streamer.sv
// Directed bench for boot_streamer: sync ROM model, tx byte monitor and a loopback echo with
// optional corruption, truncation and mid-run start pulses.
module tb_boot_streamer;
  localparam int ADR_W      = 6;
  localparam int N_WORDS    = 64;
  localparam int RX_TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             scan_req, busy, done, pass, timeout;
  logic [ADR_W:0]   err_count;
  logic [ADR_W-1:0] first_err_adr;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [15:0] rom [N_WORDS];
  logic [7:0]  tx_q [$];
  int          tx_full_hits = 0;
  int          tx_back2back = 0;
  logic        tx_en_prev = 1'b0;
  int          el;

  boot_streamer_if #(.ADR_W(ADR_W)) bus();

  boot_streamer #(.N_WORDS(N_WORDS), .ADR_W(ADR_W), .RX_TIMEOUT(RX_TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .bus             (bus),
    .scan_req_o      (scan_req),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .timeout_o       (timeout),
    .err_count_o     (err_count),
    .first_err_adr_o (first_err_adr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_adr];

  // Inputs change 1 unit after the rising edge, so the falling edge sees settled strobes.
  always @(negedge clk) begin
    if (bus.tx_en) begin
      tx_q.push_back(bus.tx_dat);
      if (bus.tx_full) tx_full_hits <= tx_full_hits + 1;
      if (tx_en_prev)  tx_back2back <= tx_back2back + 1;
    end
    tx_en_prev <= bus.tx_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_dat = b;
    bus.rx_en  = 1'b1;
    tick();
    bus.rx_en  = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_result(input string tag, input logic exp_pass, input logic exp_to,
                              input int exp_err, input int exp_first);
    check({tag, "_done"},    32'(done), 1);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_scan"},    32'(scan_req), 0);
    check({tag, "_pass"},    32'(pass), 32'(exp_pass));
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, "_errcnt"},  32'(err_count), exp_err);
    check({tag, "_firstad"}, 32'(first_err_adr), exp_first);
  endtask

  // One full image: start, wait for scan_req, check the tx stream, echo it back (corrupting the low
  // byte of words flagged in bad), optionally pulse start mid-echo, then wait for done.
  task automatic run_image(input string tag, input logic [63:0] bad, input int n_echo,
                           input int start_at, output int elapsed);
    int w;
    int nerr;
    logic [7:0] b;
    tx_q.delete();
    pulse_start();
    w = 0;
    while (!scan_req && w < 4000) begin
      tick();
      w++;
    end
    check({tag, "_scanreq"}, 32'(scan_req), 1);
    check({tag, "_txcount"}, tx_q.size(), 2 * N_WORDS);
    nerr = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      b = (i % 2 == 0) ? 8'hA5 : 8'(i / 2);
      if (tx_q[i] !== b) nerr++;
    end
    check({tag, "_txbytes"}, nerr, 0);
    for (int i = 0; i < n_echo; i++) begin
      b = (i < tx_q.size()) ? tx_q[i] : 8'h00;
      if ((i % 2 == 1) && bad[i / 2]) b = b ^ 8'h01;
      if (i == start_at) start = 1'b1;
      send_byte(b);
      start = 1'b0;
    end
    elapsed = 2;
    while (!done && elapsed < 5000) begin
      tick();
      elapsed++;
    end
  endtask

  initial begin
    int w;
    int hold_en;
    rst          = 1'b1;
    start        = 1'b0;
    bus.tx_full  = 1'b0;
    bus.rx_en    = 1'b0;
    bus.rx_dat   = '0;
    for (int i = 0; i < N_WORDS; i++) rom[i] = 16'hA500 + 16'(i);
    tick();
    tick();
    check("rst_flags", 32'({busy, done, pass, timeout, scan_req, bus.tx_en}), 0);
    check("rst_adr_dat", 32'({bus.rom_adr, bus.tx_dat}), 0);
    check("rst_err", 32'({err_count, first_err_adr}), 0);
    rst = 1'b0;
    tick();

    // 1: clean loopback
    run_image("t1", '0, 2 * N_WORDS, -1, el);
    check_result("t1", 1'b1, 1'b0, 0, 0);

    // 2: tx_full held 50 cycles while the low byte of word 5 is pending
    fork
      run_image("t2", '0, 2 * N_WORDS, -1, el);
      begin
        w = 0;
        while (tx_q.size() < 11 && w < 3000) begin
          tick();
          w++;
        end
        check("t2_reach", tx_q.size(), 11);
        bus.tx_full = 1'b1;
        hold_en = 0;
        repeat (50) begin
          tick();
          if (bus.tx_en) hold_en++;
        end
        check("t2_hold_txen", hold_en, 0);
        check("t2_hold_cnt", tx_q.size(), 11);
        bus.tx_full = 1'b0;
      end
    join
    check("t2_lo5", 32'(tx_q[11]), 32'h05);
    check_result("t2", 1'b1, 1'b0, 0, 0);

    // 3: words 7 and 40 corrupted on the echo
    run_image("t3", (64'd1 << 7) | (64'd1 << 40), 2 * N_WORDS, -1, el);
    check_result("t3", 1'b0, 1'b0, 2, 7);

    // 4: echo stops after 100 bytes
    run_image("t4", '0, 100, -1, el);
    check("t4_latency_ok", 32'(el >= RX_TIMEOUT && el <= RX_TIMEOUT + 1), 1);
    check_result("t4", 1'b0, 1'b1, 0, 0);

    // 5: reset while word 20 waits in SEND_HI, then a clean rerun
    tx_q.delete();
    pulse_start();
    w = 0;
    while (tx_q.size() < 40 && w < 3000) begin
      tick();
      w++;
    end
    check("t5_reach", tx_q.size(), 40);
    bus.tx_full = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t5_rst_flags", 32'({busy, done, pass, timeout, scan_req, bus.tx_en}), 0);
    check("t5_rst_adr_dat", 32'({bus.rom_adr, bus.tx_dat}), 0);
    check("t5_rst_err", 32'({err_count, first_err_adr}), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.tx_full = 1'b0;
    repeat (5) tick();
    check("t5_no_tx_after_rst", tx_q.size(), 40);
    check("t5_idle", 32'({busy, done}), 0);
    run_image("t5", '0, 2 * N_WORDS, -1, el);
    check_result("t5", 1'b1, 1'b0, 0, 0);

    // 6: every word corrupted, start pulsed mid-echo
    run_image("t6", '1, 2 * N_WORDS, 50, el);
    check_result("t6", 1'b0, 1'b0, N_WORDS, 0);
    repeat (20) tick();
    check("t6_done_sticky", 32'(done), 1);
    check("t6_no_restart", tx_q.size(), 2 * N_WORDS);

    check("tx_while_full", tx_full_hits, 0);
    check("tx_back2back", tx_back2back, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
